// File: rtl/pooling_sequencer.sv
// pooling_sequencer
//   Sequential 2x2 average pooling of one IMG_DIM x IMG_DIM frame. The source
//   RAM is raster-scanned one pixel per cycle. Horizontal pair sums from even
//   rows are kept in a line buffer of OUT_DIM entries. Each odd-row pair
//   completes a block, and the block average is written to the destination RAM.
//
// Build option:
//   POOL_ROUNDING_EN  defined   : wr_data = sat((sum + 2) >> 2), round-half-up
//                     undefined : wr_data = sum >> 2, truncation
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   start    in   one-cycle frame request, honoured only in IDLE
//   busy     out  high while the frame is being read or drained
//   done     out  one-cycle pulse after the last averaged pixel is written
//   rd_en    out  source RAM read enable
//   rd_addr  out  source pixel index, row*IMG_DIM+col
//   rd_data  in   source pixel, valid one cycle after rd_en
//   wr_en    out  destination write strobe
//   wr_addr  out  destination index, (row/2)*OUT_DIM+(col/2)
//   wr_data  out  averaged pixel
module pooling_sequencer #(
  parameter int RESOLUTION = 8,
  parameter int IMG_DIM    = 28,
  parameter int OUT_DIM    = IMG_DIM / 2,
  parameter int RD_AW      = $clog2(IMG_DIM * IMG_DIM),
  parameter int WR_AW      = $clog2(OUT_DIM * OUT_DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [RD_AW-1:0]      rd_addr,
  input  logic [RESOLUTION-1:0] rd_data,
  output logic                  wr_en,
  output logic [WR_AW-1:0]      wr_addr,
  output logic [RESOLUTION-1:0] wr_data
);

  localparam int CW = $clog2(IMG_DIM);
  localparam int SW = RESOLUTION + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [RD_AW-1:0]        rd_addr_q;
  logic [CW-1:0]           row_q, col_q;
  logic                    drain_q;
  logic                    last_addr;

  logic                    vld_p1;
  logic                    row_odd_p1;
  logic [CW-1:0]           col_p1;

  logic [SW-1:0]           lbuf_q [OUT_DIM];
  logic [SW-1:0]           acc_q;
  logic                    wr_en_q;
  logic [WR_AW-1:0]        wr_addr_q, wr_ptr_q;
  logic [RESOLUTION-1:0]   wr_data_q;

  logic [CW-2:0]           bidx;
  logic [SW-1:0]           pix_ext;
  logic [SW-1:0]           blk_sum;

  function automatic logic [RESOLUTION-1:0] avg_px(input logic [SW-1:0] s);
`ifdef POOL_ROUNDING_EN
    logic [SW:0] r;
    r = {1'b0, s} + (SW+1)'(2);
    // r[SW:2] is one bit wider than a pixel; a set top bit means saturate.
    if (r[SW]) return '1;
    return r[SW-1:2];
`else
    return RESOLUTION'(s >> 2);
`endif
  endfunction

  assign last_addr = (rd_addr_q == RD_AW'(IMG_DIM * IMG_DIM - 1));
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (last_addr) state_d = DRAIN;
      end
      // Two cycles: one for the last read to return, one for its write.
      DRAIN: begin
        busy = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: address and row/col counters, restarted every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      drain_q   <= 1'b0;
    end else begin
      if (state_q == RUN && !last_addr) begin
        rd_addr_q <= rd_addr_q + RD_AW'(1);
        if (col_q == CW'(IMG_DIM - 1)) begin
          col_q <= '0;
          row_q <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else begin
        rd_addr_q <= '0;
        row_q     <= '0;
        col_q     <= '0;
      end
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // Stage p1: position of the pixel arriving on rd_data this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      row_odd_p1 <= 1'b0;
      col_p1     <= '0;
    end else begin
      vld_p1     <= rd_en;
      row_odd_p1 <= row_q[0];
      col_p1     <= col_q;
    end
  end

  assign bidx    = col_p1[CW-1:1];
  assign pix_ext = SW'(rd_data);
  assign blk_sum = acc_q + pix_ext;

  // Stage p2: line-buffer accumulation and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_DIM; i++) lbuf_q[i] <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_ptr_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q == IDLE) wr_ptr_q <= '0;
      if (vld_p1) begin
        case ({row_odd_p1, col_p1[0]})
          2'b00: lbuf_q[bidx] <= pix_ext;
          2'b01: lbuf_q[bidx] <= lbuf_q[bidx] + pix_ext;
          2'b10: acc_q        <= lbuf_q[bidx] + pix_ext;
          default: begin
            // Blocks complete in raster order, so a running pointer is the address.
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_ptr_q;
            wr_data_q <= avg_px(blk_sum);
            wr_ptr_q  <= wr_ptr_q + WR_AW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pooling_sequencer.md
Name: pooling_sequencer

Overview:
- Sequences 2x2 average pooling of one IMG_DIM x IMG_DIM frame held in a pixel RAM. Produces an (IMG_DIM/2) x (IMG_DIM/2) averaged frame.
- Raster-scans the source RAM one pixel per cycle and accumulates block partial sums in an internal line buffer. Writes each averaged pixel to the downsampled RAM.
- Sits between the frame buffer and the classifier input memory. Replaces the fully parallel combinational pooling with a sequential, resource-light implementation.

Parameters:
- RESOLUTION, 8, bits per pixel.
- IMG_DIM, 28, input frame side; must be even.
- OUT_DIM, IMG_DIM/2, output frame side (derived; do not override).
- RD_AW, $clog2(IMG_DIM*IMG_DIM), source address width (10).
- WR_AW, $clog2(OUT_DIM*OUT_DIM), destination address width (8).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to pool a frame; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last averaged pixel has been written.
- rd_en  out  1  source RAM read enable.
- rd_addr  out  RD_AW  source pixel index, row*IMG_DIM+col.
- rd_data  in  RESOLUTION  source pixel; valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination write strobe.
- wr_addr  out  WR_AW  destination index, (row/2)*OUT_DIM+(col/2).
- wr_data  out  RESOLUTION  averaged pixel.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, and the line buffer and counters are cleared. Reset has priority over every other event, including mid-frame; any partial frame is abandoned and no done pulse is issued.
- FSM states:
  - IDLE: start=1 moves to RUN. Start is ignored in every other state.
  - RUN: rd_en=1 every cycle; rd_addr counts 0..IMG_DIM^2-1. After the last address, move to DRAIN.
  - DRAIN: wait 2 cycles for the last data to arrive and its write to occur, then move to DONE.
  - DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Timing with start sampled at cycle 0:
  - rd_addr=0 issued at cycle 1; rd_addr=783 issued at cycle 784.
  - The last write occurs at cycle 786; the done pulse occurs at cycle 787.
  - busy=1 over cycles 1..786.
- Datapath: a pixel issued at cycle t arrives at t+1 and is processed that cycle. A data-valid shadow of rd_en, delayed 1 cycle, qualifies processing. Row and column of the returned data are tracked by a pipelined copy of the counters.
- Line buffer: OUT_DIM entries, each RESOLUTION+2 bits wide, indexed by col/2.
  - Even row, even col: entry = pix.
  - Even row, odd col: entry += pix.
  - Odd row, even col: horizontal accumulator acc = entry + pix.
  - Odd row, odd col: sum = acc + pix; write is issued.
- Write: wr_en, wr_addr and wr_data are registered and asserted the cycle after the odd/odd pixel is processed.
  - wr_data = sum[RESOLUTION+1:2], i.e. truncation.
  - wr_en is high for exactly one cycle per output pixel, giving OUT_DIM^2 writes per frame, strictly in increasing wr_addr order.
  - wr_addr and wr_data hold their last values when wr_en=0.
- Arithmetic: sums are RESOLUTION+2 bits wide, so no overflow is possible. The maximum value 4*(2^RESOLUTION-1) still yields an output of 2^RESOLUTION-1.
- Boundaries:
  - rd_addr does not wrap within a frame; each frame restarts at 0.
  - A start asserted in the same cycle as done is ignored; start must be reasserted in IDLE.
  - Back-to-back frames are possible with a minimum gap of 1 IDLE cycle.

Optional Feature:
- Macro: POOL_ROUNDING_EN.
- Defined: wr_data = (sum + 2) >> 2, computed in RESOLUTION+3 bits and saturated to 2^RESOLUTION-1. This gives round-half-up.
- Undefined: truncating average as described in Behaviour.
- Latency and write count are identical in both builds.

Test Plan:
- Constant frame, all pixels 100; start -> 196 writes with wr_data=100, wr_addr 0..195 in order; done at cycle 787; busy high over cycles 1..786.
- Max-value frame, all pixels 255 -> every wr_data=255, no wraparound to 0 or 63.
- Block (0,0) pixels 1,1,2,2 at addresses 0,1,28,29, all other pixels 0 -> wr_addr 0 gets 1 when truncating, 2 with POOL_ROUNDING_EN; all other outputs 0.
- Pixel value equal to its index mod 256 -> each output equals the golden-model floor average; check wr_addr 13 uses source addresses 26,27,54,55.
- Start pulsed again at cycles 100 and 787 -> ignored each time: a single frame, one done pulse, no rd_addr restart.
- Reset asserted at cycle 400 for 1 cycle -> next cycle all outputs are 0 and FSM is in IDLE, no done pulse; a following start gives a full, correct 196-write frame unpolluted by stale line-buffer data.
